// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path, LSB first, with a 1-entry holding
// register (valid/ready) and single-cycle framing_error / overrun pulses.
// Build option: define UART_RX_MAJORITY_EN to take a 2-of-3 vote of rx at
// counter values target-2, target-1 and target; otherwise rx is sampled once
// at target. Decision timing is the same in both builds.
module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] EDGE_LAST   = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            sync_meta, rx, rx_prev;
  logic [CW-1:0]   clock_counter;
  logic [2:0]      bit_counter;
  logic [7:0]      shifter;
  logic            sample_bit;
  logic            start_detect;
  logic            at_sample;
  logic            byte_done;
  logic            frame_bad;

  // Two-flop synchronizer plus one more flop for falling-edge detection;
  // all idle-high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      rx        <= 1'b1;
      rx_prev   <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      rx        <= sync_meta;
      rx_prev   <= rx;
    end
  end

  // A start needs a genuine 1->0 transition, so a held-low line (break)
  // cannot retrigger once the FSM is back in IDLE.
  assign start_detect = rx_prev & ~rx;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  // rx_hist[0] is rx one cycle back (target-1), rx_hist[1] two back (target-2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_hist <= 2'b11;
    else       rx_hist <= {rx_hist[0], rx};
  end

  assign sample_bit = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx) | (rx_hist[0] & rx);
`else
  assign sample_bit = rx;
`endif

  // Next-state and sample-point decode.
  always_comb begin
    state_next = state;
    at_sample  = 1'b0;
    case (state)
      IDLE:  if (start_detect) state_next = START;
      START: if (clock_counter == SAMPLE_LAST) begin
               at_sample  = 1'b1;
               state_next = sample_bit ? IDLE : DATA;
             end
      DATA:  if (clock_counter == EDGE_LAST) begin
               at_sample = 1'b1;
               if (bit_counter == 3'd7) state_next = STOP;
             end
      STOP:  if (clock_counter == EDGE_LAST) begin
               at_sample  = 1'b1;
               state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
    byte_done = (state == STOP) & at_sample &  sample_bit;
    frame_bad = (state == STOP) & at_sample & ~sample_bit;
  end

  // State register, per-state cycle counter, bit counter and shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      clock_counter <= '0;
      bit_counter   <= '0;
      shifter       <= '0;
    end else begin
      state <= state_next;
      // Counter restarts on every state change; parked at zero while idle.
      if (state_next != state || state == IDLE) clock_counter <= '0;
      else                                     clock_counter <= clock_counter + 1'b1;
      if (state == START && at_sample) bit_counter <= '0;
      if (state == DATA && at_sample) begin
        shifter     <= {sample_bit, shifter[7:1]};
        bit_counter <= bit_counter + 1'b1;
      end
    end
  end

  // Holding register and error pulses. A completing byte wins over a
  // same-cycle read: the register is reloaded and stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      overrun       <= 1'b0;
      if (byte_done) begin
        if (!data_out_valid || data_out_ready) begin
          data_out       <= shifter;
          data_out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a transaction-level model.
// The model knows, for each frame driven, the clock edge at which the stop
// bit is decided and what byte (or framing error) results; it applies the
// holding-register rules at that edge and a compare process checks every
// output on every falling clock edge.
module tb_uart_receiver;
  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD_RATE  = 62_500;
  localparam int T = 16;           // cycles per bit
  localparam int S = 8;            // half bit
  localparam int STOP_EDGE = S + 3 + 9 * T;  // frame start drive -> output edge

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_out_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid, framing_error, overrun;

  uart_receiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error(framing_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    bit         good;
    logic [7:0] b;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0;
  int   errs = 0, checks = 0, fail_prints = 0;
  int   fe_cnt = 0, ov_cnt = 0, rise_cyc = -1;
  logic m_v = 1'b0, m_fe = 1'b0, m_ov = 1'b0, prev_v = 1'b0;
  logic [7:0] m_d = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      if (fail_prints < 40) begin
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        fail_prints++;
      end
    end
  endtask

  // Model: holding-register rules applied at each scheduled stop decision.
  always @(posedge clk) begin
    ev_t e;
    cyc++;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (reset) begin
      m_v = 1'b0;
      m_d = 8'h00;
      evq.delete();
    end else if (evq.size() > 0 && evq[0].edge_n == cyc) begin
      e = evq.pop_front();
      if (e.good) begin
        if (!m_v || data_out_ready) begin
          m_d = e.b;
          m_v = 1'b1;
        end else m_ov = 1'b1;
      end else begin
        m_fe = 1'b1;
        if (m_v && data_out_ready) m_v = 1'b0;
      end
    end else if (m_v && data_out_ready) m_v = 1'b0;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_outs", {data_out_valid, framing_error, overrun, data_out}, 32'd0);
    end else begin
      check("cycle", {data_out_valid, framing_error, overrun, data_out}, {m_v, m_fe, m_ov, m_d});
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (data_out_valid && !prev_v) rise_cyc = cyc;
    end
    prev_v = data_out_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ready();
    data_out_ready = 1'b1;
    idle(1);
    data_out_ready = 1'b0;
  endtask

  // Drive one frame, one line value per cycle. glitch forces a single low
  // cycle at that offset; abort_at stops driving early (no completion).
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [7:0] exp_b,
                            input int glitch, input int abort_at, output int t0);
    ev_t e;
    int  seg;
    logic bitv;
    t0 = cyc;
    e.edge_n = t0 + STOP_EDGE;
    e.good   = stop;
    e.b      = exp_b;
    evq.push_back(e);
    for (int j = 0; j < 10 * T; j++) begin
      if (j == abort_at) return;
      seg = j / T;
      if (seg == 0)      bitv = 1'b0;
      else if (seg == 9) bitv = stop;
      else               bitv = b[seg-1];
      if (j == glitch) bitv = 1'b0;
      serial_in = bitv;
      idle(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    errs++;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, fe0, ov0;
    logic [7:0] glitch_exp;
    idle(3);
    reset = 1'b0;
    idle(2);
    check("reset_state", {data_out_valid, framing_error, overrun, data_out}, 32'd0);

    // 1: plain frame, held until read
    send_frame(8'hA5, 1'b1, 8'hA5, -1, -1, t0);
    serial_in = 1'b1;
    idle(20);
    check("t1_data", data_out, 8'hA5);
    check("t1_valid", data_out_valid, 1'b1);
    check("t1_latency", rise_cyc - t0, 155);
    pulse_ready();
    check("t1_cleared", data_out_valid, 1'b0);
    check("t1_data_kept", data_out, 8'hA5);

    // 2: short low pulse is a false start, then a good frame
    fe0 = fe_cnt;
    serial_in = 1'b0;
    idle(4);
    serial_in = 1'b1;
    idle(2 * T);
    check("t2_no_valid", data_out_valid, 1'b0);
    send_frame(8'h3C, 1'b1, 8'h3C, -1, -1, t0);
    idle(20);
    check("t2_data", data_out, 8'h3C);
    check("t2_no_fe", fe_cnt - fe0, 0);
    pulse_ready();

    // 3: stop bit low -> one framing pulse, byte dropped; then recovery
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 8'h00, -1, -1, t0);
    serial_in = 1'b1;
    idle(2 * T);
    check("t3_fe_count", fe_cnt - fe0, 1);
    check("t3_no_valid", data_out_valid, 1'b0);
    send_frame(8'h81, 1'b1, 8'h81, -1, -1, t0);
    idle(20);
    check("t3_data", data_out, 8'h81);
    pulse_ready();

    // break: long low line gives exactly one framing pulse, no retrigger
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 8'h00, -1, -1, t0);
    idle(3 * T);
    serial_in = 1'b1;
    idle(2 * T);
    check("brk_fe_count", fe_cnt - fe0, 1);
    check("brk_no_valid", data_out_valid, 1'b0);

    // 4: back-to-back with ready low -> overrun, first byte kept
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 8'h11, -1, -1, t0);
    send_frame(8'h22, 1'b1, 8'h22, -1, -1, t1);
    idle(20);
    check("t4_data", data_out, 8'h11);
    check("t4_ov_count", ov_cnt - ov0, 1);
    pulse_ready();
    // repeat with a read on the 0x22 completion edge
    ov0 = ov_cnt;
    t0 = cyc;
    fork
      begin
        send_frame(8'h11, 1'b1, 8'h11, -1, -1, t1);
        send_frame(8'h22, 1'b1, 8'h22, -1, -1, t1);
      end
      begin
        wait (cyc == t0 + 10 * T + STOP_EDGE - 1);
        #1;
        pulse_ready();
      end
    join
    idle(20);
    check("t4r_data", data_out, 8'h22);
    check("t4r_valid", data_out_valid, 1'b1);
    check("t4r_no_ov", ov_cnt - ov0, 0);
    pulse_ready();

    // 5: async reset during data bit 4
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h99, 1'b1, 8'h99, -1, 5 * T + 8, t0);
    #2 reset = 1'b1;
    #1 check("t5_async_clear", {data_out_valid, framing_error, overrun, data_out}, 32'd0);
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    reset = 1'b0;
    idle(5);
    send_frame(8'h5A, 1'b1, 8'h5A, -1, -1, t0);
    idle(20);
    check("t5_data", data_out, 8'h5A);
    check("t5_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    pulse_ready();

    // 6: one-cycle low glitch at the bit-3 sample point
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hF7;
`endif
    send_frame(8'hFF, 1'b1, glitch_exp, S + 4 * T, -1, t0);
    idle(20);
`ifdef UART_RX_MAJORITY_EN
    check("t6_data", data_out, 8'hFF);
`else
    check("t6_data", data_out, 8'hF7);
`endif
    pulse_ready();
    idle(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
